countone_popcnt_acc: RTL and testbench



---
 rtl/countone_pkg.sv | 14 +
 rtl/countone_popcnt8.sv | 10 +
 rtl/countone_popcnt_acc.sv | 107 ++++++++++
 tb/tb_countone_popcnt_acc.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/countone_pkg.sv
// countone_pkg: shared widths and a saturating add for the countone operand stage.
package countone_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int CNT_WIDTH_DEF = 16;
  localparam int WCNT_WIDTH_DEF = $clog2(DATA_WIDTH_DEF + 1);
  // Result is {overflow, clamped sum}; w is the target width (1..32).
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b, input int unsigned w);
    logic [32:0] s;
    logic [31:0] mx;
    s = {1'b0, a} + {1'b0, b};
    mx = 32'hFFFF_FFFF >> (32 - w);
    return (s > {1'b0, mx}) ? {1'b1, mx} : s;
  endfunction
endpackage

// File: rtl/countone_popcnt8.sv
// countone_popcnt8: combinational popcount of one byte.
module countone_popcnt8 (
  input  logic [7:0] d,
  output logic [3:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, d[i]};
  end
endmodule

// File: rtl/countone_popcnt_acc.sv
// countone_popcnt_acc: per-frame saturating set-bit count, 2-stage popcount plus accumulator.
// Optional per-frame beat count output m_beats when COUNTONE_BEAT_CNT_EN is defined.
module countone_popcnt_acc
  import countone_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  m_count,
  output logic                  m_sat
`ifdef COUNTONE_BEAT_CNT_EN
  , output logic [CNT_WIDTH-1:0] m_beats
`endif
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int WW = $clog2(DATA_WIDTH + 1);
  logic [NB-1:0][3:0] bc_d, bc1_d, bc1_q;
  logic v1_d, v1_q, l1_d, l1_q, v2_d, v2_q, l2_d, l2_q;
  logic [WW-1:0] wcnt_d, wcnt_q;
  logic [CNT_WIDTH-1:0] acc_d, acc_q, m_count_d, m_count_q, sum_c;
  logic sat_d, sat_q, m_valid_d, m_valid_q, m_sat_d, m_sat_q, ovf, adv, fire, done;
  logic [32:0] acc_r;
  for (genvar g = 0; g < NB; g++) begin : g_byte
    countone_popcnt8 u_pc (.d(s_data[8*g +: 8]), .cnt(bc_d[g]));
  end
  // A held output freezes the whole pipeline, like a clock-enable stall.
  assign adv = !(m_valid_q && !m_ready);
  assign s_ready = adv;
  assign fire = adv && v2_q;
  assign done = fire && l2_q;
  always_comb begin
    bc1_d = adv ? bc_d : bc1_q;
    v1_d = adv ? s_valid : v1_q;
    l1_d = adv ? s_last : l1_q;
    wcnt_d = '0;
    for (int i = 0; i < NB; i++) wcnt_d = wcnt_d + WW'(bc1_q[i]);
    wcnt_d = adv ? wcnt_d : wcnt_q;
    v2_d = adv ? v1_q : v2_q;
    l2_d = adv ? l1_q : l2_q;
    acc_r = sat_add(32'(acc_q), 32'(wcnt_q), CNT_WIDTH);
    sum_c = CNT_WIDTH'(acc_r);
    ovf = acc_r[32];
    acc_d = fire ? (l2_q ? '0 : sum_c) : acc_q;
    sat_d = fire ? (!l2_q && (sat_q || ovf)) : sat_q;
    m_valid_d = done || (m_valid_q && !m_ready);
    m_count_d = done ? sum_c : m_count_q;
    m_sat_d = done ? (sat_q || ovf) : m_sat_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bc1_q <= '0;
      v1_q <= 1'b0;
      l1_q <= 1'b0;
      wcnt_q <= '0;
      v2_q <= 1'b0;
      l2_q <= 1'b0;
      acc_q <= '0;
      sat_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_count_q <= '0;
      m_sat_q <= 1'b0;
    end else begin
      bc1_q <= bc1_d;
      v1_q <= v1_d;
      l1_q <= l1_d;
      wcnt_q <= wcnt_d;
      v2_q <= v2_d;
      l2_q <= l2_d;
      acc_q <= acc_d;
      sat_q <= sat_d;
      m_valid_q <= m_valid_d;
      m_count_q <= m_count_d;
      m_sat_q <= m_sat_d;
    end
  end
  assign m_valid = m_valid_q;
  assign m_count = m_count_q;
  assign m_sat = m_sat_q;
`ifdef COUNTONE_BEAT_CNT_EN
  logic [CNT_WIDTH-1:0] bacc_d, bacc_q, m_beats_d, m_beats_q, bsum_c;
  logic [32:0] bacc_r;
  always_comb begin
    bacc_r = sat_add(32'(bacc_q), 32'd1, CNT_WIDTH);
    bsum_c = CNT_WIDTH'(bacc_r);
    bacc_d = fire ? (l2_q ? '0 : bsum_c) : bacc_q;
    m_beats_d = done ? bsum_c : m_beats_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bacc_q <= '0;
      m_beats_q <= '0;
    end else begin
      bacc_q <= bacc_d;
      m_beats_q <= m_beats_d;
    end
  end
  assign m_beats = m_beats_q;
`endif
endmodule

// File: tb/tb_countone_popcnt_acc.sv
// tb_countone_popcnt_acc: scoreboard bench driving a 16-bit and an 8-bit count instance in lockstep.
module tb_countone_popcnt_acc;
  logic clk = 1'b0, reset_n = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
  logic [31:0] s_data = '0;
  logic s_ready, m_valid, m_sat, s_ready8, m_valid8, m_sat8;
  logic [15:0] m_count;
  logic [7:0] m_count8;
`ifdef COUNTONE_BEAT_CNT_EN
  logic [15:0] m_beats;
  logic [7:0] m_beats8;
`endif
  typedef struct {int c16; int s16; int c8; int s8; int b16; int b8;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, total = 0, beats = 0, rdy_mode = 0;
  logic rdy_fixed = 1'b1;

  countone_popcnt_acc u_dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_count(m_count), .m_sat(m_sat)
`ifdef COUNTONE_BEAT_CNT_EN
    , .m_beats(m_beats)
`endif
  );
  countone_popcnt_acc #(.DATA_WIDTH(32), .CNT_WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready8), .s_data(s_data),
    .s_last(s_last), .m_valid(m_valid8), .m_ready(m_ready), .m_count(m_count8), .m_sat(m_sat8)
`ifdef COUNTONE_BEAT_CNT_EN
    , .m_beats(m_beats8)
`endif
  );

  always #5 clk = ~clk;

  function automatic int clampv(int v, int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a frame's expected count is its clamped total set-bit count.
  task automatic push_frame();
    exp_t e;
    e.c16 = clampv(total, 16);
    e.s16 = int'(total > 65535);
    e.c8 = clampv(total, 8);
    e.s8 = int'(total > 255);
    e.b16 = clampv(beats, 16);
    e.b8 = clampv(beats, 8);
    q.push_back(e);
    total = 0;
    beats = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    @(negedge clk);
    while (!s_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL s_ready_timeout: got 0 expected 1");
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    total += $countones(d);
    beats++;
    if (l) push_frame();
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = (rdy_mode != 0) ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    end
  end

  // Monitor: every cycle an output is presented it must match the oldest pending frame.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && (m_valid || m_valid8)) begin
        chk("valid_match", m_valid8, m_valid);
        chk("ready_match", s_ready8, s_ready);
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got count %0d expected no frame", m_count);
        end else begin
          chk("count16", m_count, q[0].c16);
          chk("sat16", m_sat, q[0].s16);
          chk("count8", m_count8, q[0].c8);
          chk("sat8", m_sat8, q[0].s8);
`ifdef COUNTONE_BEAT_CNT_EN
          chk("beats16", m_beats, q[0].b16);
          chk("beats8", m_beats8, q[0].b8);
`endif
          if (m_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int len;
    logic [31:0] d;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_count", m_count, 0);
    chk("reset_m_sat", m_sat, 0);
    chk("reset_s_ready", s_ready, 1);
    reset_n = 1'b1;
    idle(1);
    send(32'hFFFF_FFFF, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_valid && n < 10);
    chk("latency", n, 3);
    idle(3);
    send(32'h0000_000F, 1'b0);
    send(32'h8000_0001, 1'b0);
    send(32'h0000_0000, 1'b1);
    send(32'h0000_0100, 1'b1);
    idle(5);
    send(32'h3, 1'b1);
    rdy_fixed = 1'b0;
    n = 0;
    while (!m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid_seen", m_valid, 1);
    fork
      begin
        send(32'hFF, 1'b0);
        send(32'hFF, 1'b1);
      end
      begin
        repeat (10) begin
          @(negedge clk);
          chk("stall_s_ready", s_ready, 0);
          chk("stall_hold_count", m_count, 2);
        end
        rdy_fixed = 1'b1;
      end
    join
    idle(5);
    for (int i = 0; i < 9; i++) send(32'hFFFF_FFFF, i == 8);
    send(32'h1, 1'b1);
    idle(5);
    send(32'h3, 1'b1);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    #2;
    chk("pre_reset_valid", m_valid, 1);
    reset_n = 1'b0;
    total = 0;
    beats = 0;
    #1;
    chk("async_reset_valid", m_valid, 0);
    chk("async_reset_count", m_count, 0);
    chk("async_reset_valid8", m_valid8, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    send(32'h7, 1'b1);
    idle(5);
    for (int i = 0; i < 4; i++) send(32'h1, i == 3);
    send(32'h5, 1'b1);
    idle(5);
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 3))
          0: d = 32'h0;
          1: d = 32'hFFFF_FFFF;
          default: d = $urandom;
        endcase
        send(d, i == len - 1);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
    end
    rdy_mode = 0;
    rdy_fixed = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    idle(2);
    chk("drain_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
